alarm_ctrl: RTL
===============

# alarm_ctrl

Alarm controller sitting directly downstream of the time-of-day counter: it consumes the running countHr/countMin/countSec values and raises a ring output when they reach a programmed alarm time. It stores the alarm time, runs a ring/snooze/stop state machine with a bounded ring duration and a limited snooze count, and reports its state to the display/buzzer logic.

## Interface
- SNOOZE_MIN, 5: snooze length in minutes (1..59).
- RING_TIMEOUT_SEC, 60: seconds of unanswered ringing before auto-stop (1..255).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (0..7).

- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- countHr  in  8  current hour, binary 0..23, from time counter.
- countMin  in  8  current minute, binary 0..59.
- countSec  in  8  current second, binary 0..59.
- alarmEn  in  1  level; 0 disarms the alarm.
- setAlarm  in  1  one-cycle pulse; load alarmHrIn/alarmMinIn.
- alarmHrIn  in  8  requested alarm hour.
- alarmMinIn  in  8  requested alarm minute.
- snooze  in  1  one-cycle pulse, debounced upstream.
- stop  in  1  one-cycle pulse, debounced upstream.
- alarmRing  out  1  buzzer drive, high only in RINGING.
- alarmState  out  2  00 DISARMED, 01 ARMED, 10 RINGING, 11 SNOOZE.
- alarmHr  out  8  stored alarm hour.
- alarmMin  out  8  stored alarm minute.
- snoozeLeft  out  3  snoozes remaining for current event.
- setError  out  1  one-cycle pulse: setAlarm rejected.

## Operation
- Second edge: secEdge = (countSec != prevSec); prevSec registered every cycle. Ring timeout and alarm matching act only on secEdge.
- Match: secEdge && countSec==0 && countHr==targetHr && countMin==targetMin. Target is alarmHr/alarmMin in ARMED, snoozeHr/snoozeMin in SNOOZE.
- setAlarm valid iff alarmHrIn<24 and alarmMinIn<60: load alarmHr/alarmMin, snoozeLeft<=MAX_SNOOZE; if in RINGING/SNOOZE go ARMED (alarmEn=1). Invalid: registers unchanged, state unchanged, setError pulses next cycle.
- DISARMED: alarmEn=1 -> ARMED.
- ARMED: match -> RINGING, ringCnt<=0.
- RINGING: stop -> ARMED, snoozeLeft<=MAX_SNOOZE. snooze with snoozeLeft>0 -> SNOOZE, snoozeLeft decrements, snooze target = current time + SNOOZE_MIN (minute wraps 59->0 with hour+1, hour wraps 23->0). snooze with snoozeLeft==0 ignored. Each secEdge increments ringCnt; when ringCnt reaches RING_TIMEOUT_SEC -> ARMED, snoozeLeft<=MAX_SNOOZE.
- SNOOZE: match on snooze target -> RINGING, ringCnt<=0. stop -> ARMED, snoozeLeft<=MAX_SNOOZE.
- alarmEn=0: from any state -> DISARMED next cycle, snoozeLeft<=MAX_SNOOZE; alarmHr/alarmMin kept. setAlarm still loads while disarmed.
- Priority per cycle: reset > alarmEn=0 > valid setAlarm > stop > snooze > match/timeout.
- Alarm repeats daily: after stop/timeout, ARMED re-triggers at next match.

## Timing
- Reset (sync, one edge): state DISARMED, alarmRing 0, alarmHr 0, alarmMin 0, snoozeLeft MAX_SNOOZE, setError 0, ringCnt 0, snooze target 0:00, prevSec 0.
- Match sampled on cycle N -> alarmState=RINGING and alarmRing=1 from cycle N+1.
- stop/snooze on cycle N -> alarmRing=0 from N+1.
- setAlarm on N -> alarmHr/alarmMin visible from N+1; setError high exactly one cycle (N+1) if rejected.
- Timeout: alarmRing drops the cycle after the RING_TIMEOUT_SEC-th secEdge in RINGING.
- Time jumping onto hh:mm:00 (e.g. counter preset) counts as a secEdge if countSec changed; a countSec held at 0 never re-triggers.
- Valid setAlarm in same cycle as match: load wins, no ring.
- Reset mid-ring: alarmRing 0 the cycle after reset sampled.

## Test plan
- Set 07:30, alarmEn=1, drive counter 07:29:59 -> 07:30:00: alarmRing=1 one cycle after secEdge, alarmState=10.
- Ringing at 07:30:00, snooze pulse: alarmRing=0, state 11, snoozeLeft=2; counter reaches 07:35:00 -> ring again.
- Snooze at 23:57 with SNOOZE_MIN=5: re-ring at 00:02:00; after 3 snoozes a 4th snooze pulse leaves alarmRing=1, snoozeLeft=0.
- Ringing, no input, 60 second edges: alarmRing=0 after 60th, state ARMED, snoozeLeft=3; next day 07:30:00 rings.
- setAlarm 24:10 and 12:60: setError pulses once each, alarmHr/alarmMin unchanged; stop and snooze same cycle in RINGING -> ARMED.
- alarmEn=0 during RINGING -> DISARMED, alarmRing=0 next cycle; reset asserted during SNOOZE -> all outputs at reset values.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm controller fed by the time-of-day counter. Holds the programmed alarm
// time, rings when the running time reaches it, and supports a limited number
// of snoozes plus an automatic stop after a bounded period of ringing.
module alarm_ctrl #(
    parameter int SNOOZE_MIN       = 5,   // snooze length in minutes (1..59)
    parameter int RING_TIMEOUT_SEC = 60,  // unanswered ring seconds before auto-stop (1..255)
    parameter int MAX_SNOOZE       = 3    // snoozes allowed per alarm event (0..7)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] countHr,
    input  logic [7:0] countMin,
    input  logic [7:0] countSec,
    input  logic       alarmEn,
    input  logic       setAlarm,
    input  logic [7:0] alarmHrIn,
    input  logic [7:0] alarmMinIn,
    input  logic       snooze,
    input  logic       stop,
    output logic       alarmRing,
    output logic [1:0] alarmState,
    output logic [7:0] alarmHr,
    output logic [7:0] alarmMin,
    output logic [2:0] snoozeLeft,
    output logic       setError
);

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        RINGING  = 2'b10,
        SNOOZE   = 2'b11
    } state_t;

    localparam logic [2:0] SNOOZE_RELOAD = 3'(MAX_SNOOZE);
    localparam logic [7:0] SNOOZE_STEP   = 8'(SNOOZE_MIN);
    localparam logic [8:0] RING_LIMIT    = 9'(RING_TIMEOUT_SEC);

    state_t     state;
    logic [7:0] prev_sec;
    logic [7:0] snooze_hr;
    logic [7:0] snooze_min;
    logic [7:0] ring_cnt;

    logic       sec_edge;
    logic       set_valid;
    logic       alarm_match;
    logic       snooze_match;
    logic [7:0] min_sum;
    logic [7:0] next_snooze_hr;
    logic [7:0] next_snooze_min;
    logic [8:0] ring_cnt_inc;

    assign alarmState = state;

    // A new second is seen whenever the seconds value differs from last cycle,
    // so a preset that lands on hh:mm:00 still counts but a held :00 does not.
    assign sec_edge     = (countSec != prev_sec);
    assign set_valid    = setAlarm && (alarmHrIn < 8'd24) && (alarmMinIn < 8'd60);
    assign alarm_match  = sec_edge && (countSec == 8'd0) &&
                          (countHr == alarmHr) && (countMin == alarmMin);
    assign snooze_match = sec_edge && (countSec == 8'd0) &&
                          (countHr == snooze_hr) && (countMin == snooze_min);
    assign min_sum      = countMin + SNOOZE_STEP;
    assign ring_cnt_inc = {1'b0, ring_cnt} + 9'd1;

    // Snooze target: current time plus the snooze length, wrapping minute and hour.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_snooze_min = min_sum;
        next_snooze_hr  = countHr;
        if (min_sum >= 8'd60) begin
            next_snooze_min = min_sum - 8'd60;
            next_snooze_hr  = (countHr >= 8'd23) ? 8'd0 : countHr + 8'd1;
        end
    end

    // Alarm state machine with registered outputs; priority is
    // disable > valid load > stop > snooze > match/timeout.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
        if (reset) begin
            state      <= DISARMED;
            alarmRing  <= 1'b0;
            alarmHr    <= 8'd0;
            alarmMin   <= 8'd0;
            snoozeLeft <= SNOOZE_RELOAD;
            setError   <= 1'b0;
            ring_cnt   <= 8'd0;
            snooze_hr  <= 8'd0;
            snooze_min <= 8'd0;
            prev_sec   <= 8'd0;
        end else begin
            prev_sec <= countSec;
            setError <= setAlarm && !set_valid;

            if (!alarmEn) begin
                state      <= DISARMED;
                alarmRing  <= 1'b0;
                snoozeLeft <= SNOOZE_RELOAD;
                if (set_valid) begin
                    alarmHr  <= alarmHrIn;
                    alarmMin <= alarmMinIn;
                end
            end else if (set_valid) begin
                // A fresh alarm time cancels any ring or snooze in progress.
                alarmHr    <= alarmHrIn;
                alarmMin   <= alarmMinIn;
                snoozeLeft <= SNOOZE_RELOAD;
                state      <= ARMED;
                alarmRing  <= 1'b0;
            end else begin
                case (state)
                    DISARMED: begin
                        state <= ARMED;
                    end
                    ARMED: begin
                        if (alarm_match) begin
                            state     <= RINGING;
                            alarmRing <= 1'b1;
                            ring_cnt  <= 8'd0;
                        end
                    end
                    RINGING: begin
                        if (stop) begin
                            state      <= ARMED;
                            alarmRing  <= 1'b0;
                            snoozeLeft <= SNOOZE_RELOAD;
                        end else if (snooze && (snoozeLeft != 3'd0)) begin
                            state      <= SNOOZE;
                            alarmRing  <= 1'b0;
                            snoozeLeft <= snoozeLeft - 3'd1;
                            snooze_hr  <= next_snooze_hr;
                            snooze_min <= next_snooze_min;
                        end else if (sec_edge) begin
                            if (ring_cnt_inc == RING_LIMIT) begin
                                state      <= ARMED;
                                alarmRing  <= 1'b0;
                                snoozeLeft <= SNOOZE_RELOAD;
                            end else begin
                                ring_cnt <= ring_cnt_inc[7:0];
                            end
                        end
                    end
                    SNOOZE: begin
                        if (stop) begin
                            state      <= ARMED;
                            snoozeLeft <= SNOOZE_RELOAD;
                        end else if (snooze_match) begin
                            state     <= RINGING;
                            alarmRing <= 1'b1;
                            ring_cnt  <= 8'd0;
                        end
                    end
                    default: begin
                        state     <= DISARMED;
                        alarmRing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
